dab_gate_driver: RTL

- Downstream stage of the DAB phase-shift modulator.
- Converts the modulator's signed 3-level bridge voltage commands (V1 for the primary bridge, V2 for the secondary bridge) into eight gate signals: four primary (sp), four secondary (ss).
- Inserts a programmable deadtime on every leg commutation, provides enable and fault-latched safe-off, and delays the scope trigger to stay aligned with the gates.

---
 rtl/dab_gate_driver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dab_gate_driver.sv
// Gate driver for the DAB phase-shift modulator: turns the signed 3-level bridge
// commands into eight deadtime-protected gate signals with enable and latched fault-off.

module dab_gate_leg #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            tgt_hi_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic            hi_o,
  output logic            lo_o
);

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_HIGH,
    S_DTH,
    S_DTL
  } leg_state_e;

  leg_state_e      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hi_q, lo_q;
  logic            dt_zero;

  assign dt_zero = (deadtime_i == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill_i) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (dt_zero) state_d = tgt_hi_i ? S_HIGH : S_LOW;
          else         state_d = tgt_hi_i ? S_DTH : S_DTL;
          cnt_d = deadtime_i;
        end
        S_LOW: begin
          if (tgt_hi_i) begin
            state_d = dt_zero ? S_HIGH : S_DTH;
            cnt_d   = deadtime_i;
          end
        end
        S_HIGH: begin
          if (!tgt_hi_i) begin
            state_d = dt_zero ? S_LOW : S_DTL;
            cnt_d   = deadtime_i;
          end
        end
        // A reversal mid-count restarts the full deadtime in the other direction;
        // cnt <= 1 also covers a zero reload so the counter never wraps.
        S_DTH: begin
          if (!tgt_hi_i) begin
            state_d = S_DTL;
            cnt_d   = deadtime_i;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = S_HIGH;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        S_DTL: begin
          if (tgt_hi_i) begin
            state_d = S_DTH;
            cnt_d   = deadtime_i;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = S_LOW;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Gate registers are decoded from the next state so they switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= (state_d == S_HIGH);
      lo_q    <= (state_d == S_LOW);
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

module dab_gate_driver #(
  parameter int DT_W      = 8,
  parameter int ZERO_HIGH = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            fault_in,
  input  logic [DT_W-1:0] deadtime,
  input  logic [1:0]      v1,
  input  logic [1:0]      v2,
  input  logic            trigger_in,
  output logic [3:0]      sp,
  output logic [3:0]      ss,
  output logic            trigger_out,
  output logic            fault_latched
);

  logic signed [1:0] v1_q, v2_q;
  logic              trig_q, trig2_q;
  logic              fault_q;
  logic              kill;
  logic [3:0]        tgt_hi;
  logic [3:0]        hi, lo;

  // Returns {leg B high, leg A high}; the illegal code 10 falls through to zero.
  function automatic logic [1:0] leg_targets(input logic signed [1:0] v);
    if (v == 2'sb01)      return 2'b01;
    else if (v == 2'sb11) return 2'b10;
    else                  return (ZERO_HIGH != 0) ? 2'b11 : 2'b00;
  endfunction

  // Input stage
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= '0;
      v2_q    <= '0;
      trig_q  <= 1'b0;
      trig2_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      v1_q    <= $signed(v1);
      v2_q    <= $signed(v2);
      trig_q  <= trigger_in;
      trig2_q <= trig_q;
      if (fault_in) fault_q <= 1'b1;
    end
  end

  // The raw fault input kills the legs on the same edge it is latched
  assign kill   = fault_in | fault_q | ~en;
  assign tgt_hi = {leg_targets(v2_q), leg_targets(v1_q)};

  // Leg stage: [0] primary A, [1] primary B, [2] secondary A, [3] secondary B
  for (genvar g = 0; g < 4; g++) begin : g_leg
    dab_gate_leg #(.DT_W(DT_W)) u_leg (
      .clk        (clk),
      .rst        (rst),
      .kill_i     (kill),
      .tgt_hi_i   (tgt_hi[g]),
      .deadtime_i (deadtime),
      .hi_o       (hi[g]),
      .lo_o       (lo[g])
    );
  end

  assign sp            = {lo[1], hi[1], lo[0], hi[0]};
  assign ss            = {lo[3], hi[3], lo[2], hi[2]};
  assign trigger_out   = trig2_q;
  assign fault_latched = fault_q;

endmodule
